// File: rtl/uart_program_loader.sv
// Boot loader: UART 8N1 image (BE word count, then BE words) -> program memory write port.
// Latency: ProgWrite 1 cycle after the 4th byte of a word; Done 1 cycle after the final write. No backpressure: UART input cannot be stalled.
// LOADER_ECHO_EN: when defined, accepted header/payload bytes are echoed on RsTx through a 1-entry holding register.
module uart_program_loader #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  RsRx,
    output logic                  RsTx,
    output logic [ADDR_WIDTH-1:0] ProgAddr,
    output logic [31:0]           ProgData,
    output logic                  ProgWrite,
    output logic                  Done,
    output logic                  Busy,
    output logic                  Error
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int CNTW         = ADDR_WIDTH - 1;
    localparam logic [31:0]   MAX_WORDS = 32'((2 ** ADDR_WIDTH) / 4);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic          rx_s0, rx_s1, rx_prev;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic          byte_valid, frame_err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s0      <= 1'b1;
            rx_s1      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bits    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s0      <= RsRx;
            rx_s1      <= rx_s0;
            rx_prev    <= rx_s1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s1) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Mid-start re-check: a line already back high was a glitch.
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_s1 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s1, rx_shift[7:1]};
                        if (rx_bits == 3'd7) rx_state <= RX_STOP;
                        else                 rx_bits  <= rx_bits + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    // Back to idle at mid-stop so the next start edge is never missed.
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s1) byte_valid <= 1'b1;
                        else       frame_err  <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    logic [1:0]      state;
    logic [1:0]      byte_idx;
    logic            got_byte;
    logic [23:0]     hdr;
    logic [31:0]     hdr_next;
    logic [CNTW-1:0] n_words, word_cnt, word_cnt_inc;

    assign hdr_next     = {hdr, rx_shift};
    assign word_cnt_inc = word_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_HDR;
            byte_idx  <= '0;
            got_byte  <= 1'b0;
            hdr       <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
            ProgAddr  <= '0;
            ProgData  <= '0;
            ProgWrite <= 1'b0;
        end else begin
            ProgWrite <= 1'b0;
            if (ProgWrite) begin
                ProgAddr <= ProgAddr + ADDR_WIDTH'(4);
                word_cnt <= word_cnt_inc;
                if (word_cnt_inc == n_words) state <= ST_DONE;
            end
            case (state)
                ST_HDR: begin
                    if (frame_err) begin
                        state <= ST_ERR;
                    end else if (byte_valid) begin
                        got_byte <= 1'b1;
                        hdr      <= hdr_next[23:0];
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            if (hdr_next == 32'd0) begin
                                state <= ST_DONE;
                            end else if (hdr_next > MAX_WORDS) begin
                                state <= ST_ERR;
                            end else begin
                                state    <= ST_DATA;
                                n_words  <= hdr_next[CNTW-1:0];
                                word_cnt <= '0;
                                ProgAddr <= '0;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (frame_err) begin
                        state <= ST_ERR;
                    end else if (byte_valid) begin
                        ProgData <= {ProgData[23:0], rx_shift};
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) ProgWrite <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Done  = (state == ST_DONE);
    assign Error = (state == ST_ERR);
    assign Busy  = (state == ST_DATA) || ((state == ST_HDR) && got_byte);

`ifdef LOADER_ECHO_EN
    logic          hold_vld;
    logic [7:0]    hold_dat;
    logic          tx_busy, tx_line, tx_last, tx_load, accept;
    logic [9:0]    tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bits;

    assign accept  = byte_valid && ((state == ST_HDR) || (state == ST_DATA));
    // Reloading in the stop bit's last cycle keeps the TX frame period equal to RX.
    assign tx_last = tx_busy && (tx_cnt == FULL_M1) && (tx_bits == 4'd9);
    assign tx_load = hold_vld && (!tx_busy || tx_last);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_line <= tx_busy ? tx_shift[0] : 1'b1;
            if (tx_load) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, hold_dat, 1'b0};
                tx_cnt   <= '0;
                tx_bits  <= '0;
                hold_vld <= 1'b0;
            end else if (tx_busy) begin
                if (tx_cnt == FULL_M1) begin
                    tx_cnt   <= '0;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    if (tx_bits == 4'd9) tx_busy <= 1'b0;
                    else                 tx_bits <= tx_bits + 1'b1;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
            if (accept) begin
                hold_dat <= rx_shift;
                hold_vld <= 1'b1;
            end
        end
    end

    assign RsTx = tx_line;
`else
    assign RsTx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a write scoreboard and an optional echo decoder.
module tb_uart_program_loader;
    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int AW     = 10;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          RsRx = 1'b1;
    logic          RsTx;
    logic [AW-1:0] ProgAddr;
    logic [31:0]   ProgData;
    logic          ProgWrite, Done, Busy, Error;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        bit            last;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] echo_q[$];
    int         checks = 0;
    int         failures = 0;
    bit         done_due = 1'b0;
    bit         prev_write = 1'b0;
    bit         tx_low_seen = 1'b0;

    uart_program_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .RsRx(RsRx), .RsTx(RsTx),
        .ProgAddr(ProgAddr), .ProgData(ProgData), .ProgWrite(ProgWrite),
        .Done(Done), .Busy(Busy), .Error(Error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d, input bit last);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RsRx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RsRx = b[i];
            repeat (CPB) @(negedge clk);
        end
        RsRx = stop;
        repeat (CPB) @(negedge clk);
        RsRx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        RsRx = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic check_reset(input string p);
        chk({p, "_addr"}, 32'(ProgAddr), 0);
        chk({p, "_data"}, ProgData, 0);
        chk({p, "_write"}, 32'(ProgWrite), 0);
        chk({p, "_done"}, 32'(Done), 0);
        chk({p, "_busy"}, 32'(Busy), 0);
        chk({p, "_error"}, 32'(Error), 0);
        chk({p, "_rstx"}, 32'(RsTx), 1);
    endtask

    task automatic rx_echo();
        int         w = 0;
        logic [7:0] b = '0;
        logic [7:0] e;
        while (RsTx !== 1'b0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("echo_start_seen", 32'(RsTx === 1'b0), 1);
        repeat (CPB / 2) @(negedge clk);
        chk("echo_start_bit", 32'(RsTx), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = RsTx;
        end
        e = (echo_q.size() != 0) ? echo_q.pop_front() : 8'hxx;
        chk("echo_byte", 32'(b), 32'(e));
        repeat (CPB) @(negedge clk);
        chk("echo_stop_bit", 32'(RsTx), 1);
    endtask

    // Write scoreboard: each ProgWrite pulse pops the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (RsTx !== 1'b1) tx_low_seen = 1'b1;
        if (done_due) begin
            chk("done_after_last_write", 32'(Done), 1);
            done_due = 1'b0;
        end
        if (ProgWrite === 1'b1) begin
            chk("write_single_cycle", 32'(prev_write), 0);
            chk("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(ProgAddr), 32'(e.addr));
                chk("write_data", ProgData, e.data);
                chk("done_low_during_write", 32'(Done), 0);
                if (e.last) done_due = 1'b1;
            end
        end
        prev_write = (ProgWrite === 1'b1);
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        check_reset("por");

        // Two-word image.
        push_wr(0, 32'h24080005, 1'b0);
        push_wr(4, 32'h0000000C, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("t1_busy_after_first_hdr", 32'(Busy), 1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(32'h24080005);
        send_word(32'h0000000C);
        repeat (4) @(negedge clk);
        chk("t1_done", 32'(Done), 1);
        chk("t1_busy", 32'(Busy), 0);
        chk("t1_error", 32'(Error), 0);
        chk("t1_addr", 32'(ProgAddr), 8);
        chk("t1_writes_drained", exp_q.size(), 0);

        // Empty image: Done one cycle after the 4th header byte.
        pulse_reset();
        chk("t2_done_cleared", 32'(Done), 0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        n = 0;
        fork
            send_byte(8'h00, 1'b1);
            begin
                while (Done !== 1'b1 && n < 300) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        checks++;
        assert (n >= 155 && n <= 157) else begin
            failures++;
            $error("FAIL n0_done_latency observed=%0d expected=155..157", n);
        end
        chk("t2_busy", 32'(Busy), 0);
        send_byte(8'h77, 1'b1);
        chk("t2_done_sticky", 32'(Done), 1);
        chk("t2_error", 32'(Error), 0);
        chk("t2_data_untouched", ProgData, 0);

        // Oversized image (257 words).
        pulse_reset();
        send_word(32'h00000101);
        chk("t3_error", 32'(Error), 1);
        chk("t3_done", 32'(Done), 0);
        chk("t3_busy", 32'(Busy), 0);
        send_word(32'hAABBCCDD);
        chk("t3_error_sticky", 32'(Error), 1);
        chk("t3_data_ignored", ProgData, 0);
        chk("t3_addr", 32'(ProgAddr), 0);

        // Framing error on the second payload byte, then recovery.
        pulse_reset();
        send_word(32'h00000001);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("t4_error", 32'(Error), 1);
        chk("t4_busy", 32'(Busy), 0);
        pulse_reset();
        check_reset("t4_rst");
        push_wr(0, 32'hCAFEF00D, 1'b1);
        send_word(32'h00000001);
        send_word(32'hCAFEF00D);
        repeat (4) @(negedge clk);
        chk("t4_reload_done", 32'(Done), 1);
        chk("t4_reload_error", 32'(Error), 0);

        // Half-bit glitch in idle.
        pulse_reset();
        RsRx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        RsRx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("t5_glitch_busy", 32'(Busy), 0);
        chk("t5_glitch_error", 32'(Error), 0);
        chk("t5_glitch_done", 32'(Done), 0);

        // Reset in the middle of the second word.
        push_wr(0, 32'h11223344, 1'b0);
        send_word(32'h00000002);
        send_word(32'h11223344);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        chk("t5_addr_before_reset", 32'(ProgAddr), 4);
        RsRx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        pulse_reset();
        chk("t5_addr_after_reset", 32'(ProgAddr), 0);
        chk("t5_busy_after_reset", 32'(Busy), 0);
        chk("t5_data_after_reset", ProgData, 0);
        repeat (12 * CPB) @(negedge clk);
        push_wr(0, 32'h0BADBEEF, 1'b1);
        send_word(32'h00000001);
        send_word(32'h0BADBEEF);
        repeat (4) @(negedge clk);
        chk("t5_reload_done", 32'(Done), 1);

`ifdef LOADER_ECHO_EN
        pulse_reset();
        echo_q.push_back(8'hA5);
        echo_q.push_back(8'h3C);
        fork
            begin
                send_byte(8'hA5, 1'b1);
                send_byte(8'h3C, 1'b1);
            end
            begin
                rx_echo();
                rx_echo();
            end
        join
`else
        chk("rstx_idle", 32'(tx_low_seen), 0);
`endif

        repeat (4) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
